ula_verificador: RTL and testbench

- Hardware self-test sequencer and response checker for the 2-bit ULA (Sel[3:0], A[1:0], B[1:0] -> Saida[2:0]).
- Drives all 256 Sel/A/B combinations into the ULA, samples Saida and compares it against an internal golden model.
- Reports pass/fail, the mismatch count and the first failing vector.
- Sits beside the ULA as its stimulus source and result consumer: the on-chip counterpart of the bench sweep.

---
 rtl/ula_verificador.sv | 159 +++++++++++++++
 tb/tb_ula_verificador.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_verificador.sv
// ula_verificador: self-test sequencer and response checker for the 2-bit ULA.
// Sweeps all 256 Sel/A/B vectors (Sel outermost, B innermost), samples Saida
// SETTLE cycles after each vector is applied, and compares it with an internal
// golden model. Reports pass/fail, the mismatch count and the first failing vector.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             begin a sweep; honoured only in IDLE or DONE
//   Sel, A, B         registered stimulus to the ULA
//   Saida             ULA result
//   busy, done, pass  sweep status; pass valid while done=1
//   err_count         number of mismatching vectors (0..256)
//   fail_*            Sel/A/B, observed Saida and expected value of the first mismatch
module ula_verificador #(
  parameter int unsigned SETTLE = 1  // legal range 1..15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [3:0] Sel,
  output logic [1:0] A,
  output logic [1:0] B,
  input  logic [2:0] Saida,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [8:0] err_count,
  output logic [3:0] fail_sel,
  output logic [1:0] fail_a,
  output logic [1:0] fail_b,
  output logic [2:0] fail_saida,
  output logic [2:0] fail_esperado
);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, FINISHED} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state_q;
  logic [7:0] idx_q;
  logic [3:0] cnt_q;
  logic       busy_q, done_q, pass_q;
  logic [8:0] err_q;
  logic [3:0] fsel_q;
  logic [1:0] fa_q, fb_q;
  logic [2:0] fsaida_q, fesp_q;

  logic [2:0] esperado;
  logic       mismatch;

  function automatic logic [2:0] golden(input logic [3:0] s, input logic [1:0] a,
                                        input logic [1:0] b);
    logic [2:0] ea, eb, r;
    ea = {1'b0, a};
    eb = {1'b0, b};
    r  = '0;
    case (s)
      4'd0:        r = ea + eb;
      4'd1:        r = ea - eb;
      4'd2:        r = ea * eb;
      4'd3:        r = (b == 2'd0) ? 3'b111 : ea / eb;
      4'd4:        r = {a, 1'b0};
      4'd5:        r = {2'b00, a[1]};
      4'd6, 4'd7:  r = {1'b0, a[0], a[1]};
      4'd8:        r = {1'b0, a & b};
      4'd9:        r = {1'b0, a | b};
      4'd10:       r = {1'b0, a ^ b};
      4'd11:       r = {1'b0, ~(a & b)};
      4'd12:       r = {1'b0, ~(a | b)};
      4'd13:       r = {1'b0, ~(a ^ b)};
      4'd14:       r = {2'b00, a > b};
      default:     r = {2'b00, a == b};
    endcase
    return r;
  endfunction

  always_comb begin
    esperado = golden(idx_q[7:4], idx_q[3:2], idx_q[1:0]);
    mismatch = (Saida != esperado);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fsel_q   <= '0;
      fa_q     <= '0;
      fb_q     <= '0;
      fsaida_q <= '0;
      fesp_q   <= '0;
    end else begin
      case (state_q)
        IDLE, FINISHED: begin
          if (start) begin
            state_q  <= DRIVE;
            idx_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            fsel_q   <= '0;
            fa_q     <= '0;
            fb_q     <= '0;
            fsaida_q <= '0;
            fesp_q   <= '0;
          end
        end
        DRIVE: begin
          if (cnt_q == SETTLE_LAST) state_q <= CHECK;
          else                      cnt_q   <= cnt_q + 4'd1;
        end
        CHECK: begin
          if (mismatch) begin
            err_q <= err_q + 9'd1;
            if (err_q == '0) begin
              fsel_q   <= idx_q[7:4];
              fa_q     <= idx_q[3:2];
              fb_q     <= idx_q[1:0];
              fsaida_q <= Saida;
              fesp_q   <= esperado;
            end
          end
          if (idx_q == 8'hFF) begin
            // pass must account for the mismatch being counted in this same cycle
            state_q <= FINISHED;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_q == '0) && !mismatch;
          end else begin
            state_q <= DRIVE;
            idx_q   <= idx_q + 8'd1;
            cnt_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Sel           = idx_q[7:4];
  assign A             = idx_q[3:2];
  assign B             = idx_q[1:0];
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign fail_sel      = fsel_q;
  assign fail_a        = fa_q;
  assign fail_b        = fb_q;
  assign fail_saida    = fsaida_q;
  assign fail_esperado = fesp_q;

endmodule

// File: tb/tb_ula_verificador.sv
// Bench for ula_verificador: two instances (SETTLE=1 and SETTLE=3) each driven by
// a behavioural ULA with selectable fault injection. Expected sweep results are
// queued at start; a monitor pops and compares them when done rises.
module tb_ula_verificador;

  typedef struct {
    int unsigned cycles;
    logic        pass;
    logic [8:0]  errc;
    logic [3:0]  fsel;
    logic [1:0]  fa, fb;
    logic [2:0]  fsaida, fesp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start1 = 1'b0, start3 = 1'b0;
  logic use3 = 1'b0;
  int   fm = 0;  // 0 clean, 1 Sel3/A2/B0 returns 0, 2 Sel14 flips bit0
  int   cyc = 0;
  int   checks = 0, errors = 0;
  exp_t exp_q[$];

  logic [3:0] sel1, sel3, fsel1, fsel3;
  logic [1:0] a1, a3, b1, b3, fa1, fa3, fb1, fb3;
  logic [2:0] saida1, saida3, fsa1, fsa3, fe1, fe3;
  logic       busy1, busy3, done1, done3, pass1, pass3;
  logic [8:0] err1, err3;

  ula_verificador #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .Sel(sel1), .A(a1), .B(b1),
    .Saida(saida1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_sel(fsel1), .fail_a(fa1), .fail_b(fb1), .fail_saida(fsa1),
    .fail_esperado(fe1));

  ula_verificador #(.SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .Sel(sel3), .A(a3), .B(b3),
    .Saida(saida3), .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .fail_sel(fsel3), .fail_a(fa3), .fail_b(fb3), .fail_saida(fsa3),
    .fail_esperado(fe3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [2:0] ula(input logic [3:0] s, input logic [1:0] a,
                                     input logic [1:0] b, input int mode);
    int ra, rb, r;
    logic [2:0] o;
    ra = int'(a);
    rb = int'(b);
    case (int'(s))
      0: r = ra + rb;
      1: r = ra - rb;
      2: r = ra * rb;
      3: r = (rb == 0) ? 7 : ra / rb;
      4: r = ra * 2;
      5: r = ra / 2;
      6, 7: r = (ra % 2) * 2 + ra / 2;
      8: r = int'(a & b);
      9: r = int'(a | b);
      10: r = int'(a ^ b);
      11: r = 3 - int'(a & b);
      12: r = 3 - int'(a | b);
      13: r = 3 - int'(a ^ b);
      14: r = (ra > rb) ? 1 : 0;
      default: r = (ra == rb) ? 1 : 0;
    endcase
    r = r & 7;
    o = r[2:0];
    if (mode == 1 && s == 4'd3 && a == 2'd2 && b == 2'd0) o = 3'd0;
    if (mode == 2 && s == 4'd14) o[0] = ~o[0];
    return o;
  endfunction

  always_comb saida1 = ula(sel1, a1, b1, fm);
  always_comb saida3 = ula(sel3, a3, b3, fm);

  logic       m_busy, m_done, m_pass;
  logic [8:0] m_err;
  logic [3:0] m_sel, m_fsel;
  logic [1:0] m_a, m_b, m_fa, m_fb;
  logic [2:0] m_fsa, m_fe;
  always_comb begin
    m_busy = use3 ? busy3 : busy1;
    m_done = use3 ? done3 : done1;
    m_pass = use3 ? pass3 : pass1;
    m_err  = use3 ? err3  : err1;
    m_sel  = use3 ? sel3  : sel1;
    m_a    = use3 ? a3    : a1;
    m_b    = use3 ? b3    : b1;
    m_fsel = use3 ? fsel3 : fsel1;
    m_fa   = use3 ? fa3   : fa1;
    m_fb   = use3 ? fb3   : fb1;
    m_fsa  = use3 ? fsa3  : fsa1;
    m_fe   = use3 ? fe3   : fe1;
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: vector walk order, sweep length and final results.
  logic       p_busy = 1'b0, p_done = 1'b0;
  logic [7:0] last_vec = '0;
  int         t0 = 0;
  always @(negedge clk) begin
    exp_t e;
    logic [7:0] vec;
    vec = {m_sel, m_a, m_b};
    if (!rst_n) begin
      p_busy = 1'b0;
      p_done = 1'b0;
    end else begin
      if (m_busy && !p_busy) begin
        t0 = cyc;
        chk("first_vector", int'(vec), 0);
        last_vec = vec;
      end else if (m_busy && vec != last_vec) begin
        chk("vector_order", int'(vec), int'(last_vec) + 1);
        last_vec = vec;
      end
      if (m_done && !p_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sweep_cycles", cyc - t0, int'(e.cycles));
          chk("last_vector", int'(vec), 255);
          chk("busy_at_done", int'(m_busy), 0);
          chk("pass", int'(m_pass), int'(e.pass));
          chk("err_count", int'(m_err), int'(e.errc));
          chk("fail_sel", int'(m_fsel), int'(e.fsel));
          chk("fail_a", int'(m_fa), int'(e.fa));
          chk("fail_b", int'(m_fb), int'(e.fb));
          chk("fail_saida", int'(m_fsa), int'(e.fsaida));
          chk("fail_esperado", int'(m_fe), int'(e.fesp));
        end
      end
      p_busy = m_busy;
      p_done = m_done;
    end
  end

  task automatic push(input int unsigned cy, input logic ps, input int ec,
                      input int s, input int a, input int b, input int sa, input int es);
    exp_t e;
    e.cycles = cy; e.pass = ps; e.errc = 9'(ec);
    e.fsel = 4'(s); e.fa = 2'(a); e.fb = 2'(b); e.fsaida = 3'(sa); e.fesp = 3'(es);
    exp_q.push_back(e);
  endtask

  task automatic pulse_start(input string name);
    @(posedge clk); #1;
    if (use3) start3 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    start3 = 1'b0;
    chk({name, "_busy_rise"}, int'(m_busy), 1);
    chk({name, "_done_clear"}, int'(m_done), 0);
    chk({name, "_err_clear"}, int'(m_err), 0);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!m_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!m_done) chk({name, "_timeout"}, 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    #12;
    chk("reset_status", int'({busy1, done1, pass1, err1}), 0);
    chk("reset_vector", int'({sel1, a1, b1}), 0);
    chk("reset_fail", int'({fsel1, fa1, fb1, fsa1, fe1}), 0);
    chk("reset_dut3", int'({busy3, done3, pass3, err3, sel3, a3, b3}), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Clean pass
    fm = 0;
    push(512, 1'b1, 0, 0, 0, 0, 0, 0);
    pulse_start("clean");
    wait_done("clean", 600);

    // Single fault, restarted from DONE
    fm = 1;
    push(512, 1'b0, 1, 3, 2, 0, 0, 7);
    pulse_start("single");
    wait_done("single", 600);
    chk("vector_held_done", int'({sel1, a1, b1}), 255);

    // Multiple faults on every Sel=14 vector
    fm = 2;
    push(512, 1'b0, 16, 14, 0, 0, 1, 0);
    pulse_start("multi");
    wait_done("multi", 600);

    // Start pulses while busy must not restart the sweep
    fm = 0;
    push(512, 1'b1, 0, 0, 0, 0, 0, 0);
    pulse_start("busy_start");
    repeat (9) @(posedge clk);
    #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    repeat (289) @(posedge clk);
    #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    wait_done("busy_start", 600);

    // Reset mid-run: outputs clear without waiting for a clock edge
    pulse_start("abort");
    repeat (199) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_status", int'({busy1, done1, pass1, err1}), 0);
    chk("abort_vector", int'({sel1, a1, b1}), 0);
    chk("abort_fail", int'({fsel1, fa1, fb1, fsa1, fe1}), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    push(512, 1'b1, 0, 0, 0, 0, 0, 0);
    pulse_start("after_abort");
    wait_done("after_abort", 600);

    // SETTLE=3: faulty run, then clean restart from DONE
    use3 = 1'b1;
    fm = 1;
    push(1024, 1'b0, 1, 3, 2, 0, 0, 7);
    pulse_start("s3_fault");
    wait_done("s3_fault", 1100);
    fm = 0;
    push(1024, 1'b1, 0, 0, 0, 0, 0, 0);
    pulse_start("s3_clean");
    chk("s3_fail_cleared", int'({fsel3, fa3, fb3, fsa3, fe3}), 0);
    wait_done("s3_clean", 1100);

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
